// File: rtl/udp_reg_responder.sv
// Register-ring responder: answers tagged requests from a bank of RW control
// registers and free-running event counters. Optional macro: UDP_REG_RESPONDER_CLR_ON_READ_EN.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_responder #(
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned BLOCK_ADDR_WIDTH  = 4,
  parameter int unsigned TAG               = 0,
  parameter int unsigned NUM_RW_REGS       = 4,
  parameter int unsigned NUM_CNTRS         = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                reg_req_in,
  input  logic                                reg_ack_in,
  input  logic                                reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in,
  output logic                                reg_req_out,
  output logic                                reg_ack_out,
  output logic                                reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,
  output logic [NUM_RW_REGS*32-1:0]           rw_regs,
  input  logic [NUM_CNTRS-1:0]                cnt_inc
);

  localparam int unsigned AW    = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DW    = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned TAG_W = AW - BLOCK_ADDR_WIDTH;

  logic                         req_q,  req_d;
  logic                         ack_q,  ack_d;
  logic                         rd_q,   rd_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [DW-1:0]                data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q,  src_d;
  logic [NUM_RW_REGS-1:0][31:0] rw_q,   rw_d;
  logic [NUM_CNTRS-1:0][31:0]   cnt_q,  cnt_d;

  logic                         hit_c;
  logic [BLOCK_ADDR_WIDTH-1:0]  idx_c;

  assign hit_c = reg_req_in & ~reg_ack_in &
                 (reg_addr_in[AW-1:BLOCK_ADDR_WIDTH] == TAG_W'(TAG));
  assign idx_c = reg_addr_in[BLOCK_ADDR_WIDTH-1:0];

  // Ring pass-through with local decode; reads see pre-edge register state.
  always_comb begin
    req_d  = reg_req_in;
    ack_d  = reg_ack_in;
    rd_d   = reg_rd_wr_L_in;
    addr_d = reg_addr_in;
    data_d = reg_data_in;
    src_d  = reg_src_in;
    rw_d   = rw_q;
    for (int i = 0; i < int'(NUM_CNTRS); i++) begin
      cnt_d[i] = cnt_q[i] + 32'(cnt_inc[i]);
    end

    if (hit_c) begin
      ack_d = 1'b1;
      if (reg_rd_wr_L_in) begin
        data_d = DW'(32'hDEAD_BEEF);
        for (int i = 0; i < int'(NUM_RW_REGS); i++) begin
          if (idx_c == BLOCK_ADDR_WIDTH'(i)) data_d = DW'(rw_q[i]);
        end
        for (int i = 0; i < int'(NUM_CNTRS); i++) begin
          if (idx_c == BLOCK_ADDR_WIDTH'(int'(NUM_RW_REGS) + i)) begin
            data_d = DW'(cnt_q[i]);
`ifdef UDP_REG_RESPONDER_CLR_ON_READ_EN
            // Restart from this cycle's event so nothing is lost.
            cnt_d[i] = 32'(cnt_inc[i]);
`endif
          end
        end
      end else begin
        for (int i = 0; i < int'(NUM_RW_REGS); i++) begin
          if (idx_c == BLOCK_ADDR_WIDTH'(i)) rw_d[i] = 32'(reg_data_in);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= 1'b0;
      ack_q  <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      src_q  <= '0;
      rw_q   <= '0;
      cnt_q  <= '0;
    end else begin
      req_q  <= req_d;
      ack_q  <= ack_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      src_q  <= src_d;
      rw_q   <= rw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rd_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;
  assign rw_regs         = rw_q;

endmodule
